// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU sharing arbiter.
// Funct3 codes follow the RISC-V OP/OP-IMM encoding.
package alu_arb_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0] in0;
      logic [XLEN-1:0] in1;
      logic [2:0]      func3;
      logic            sub;
   } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle for the two ALU requester ports.
interface alu_share_arbiter_if;
   import alu_arb_pkg::*;

   logic [1:0]           REQ_VALID;
   logic [1:0]           REQ_READY;
   logic [1:0][XLEN-1:0] REQ_IN0;
   logic [1:0][XLEN-1:0] REQ_IN1;
   logic [1:0][2:0]      REQ_FUNC3;
   logic [1:0]           REQ_SUB;
   logic [1:0]           RSP_VALID;
   logic [1:0]           RSP_READY;
   logic [1:0][XLEN-1:0] RSP_DATA;

   modport master (
      output REQ_VALID, REQ_IN0, REQ_IN1, REQ_FUNC3, REQ_SUB, RSP_READY,
      input  REQ_READY, RSP_VALID, RSP_DATA
   );

   modport slave (
      input  REQ_VALID, REQ_IN0, REQ_IN1, REQ_FUNC3, REQ_SUB, RSP_READY,
      output REQ_READY, RSP_VALID, RSP_DATA
   );

endinterface

// File: rtl/ALU_DataPath.sv
// Fixed-width RV32 integer ALU; output is forced to zero when not enabled.
module ALU_DataPath
   import alu_arb_pkg::*;
(
   input  logic            ALU_EN,
   input  alu_req_t        REQ,
   output logic [XLEN-1:0] OUT
);

   logic [4:0] shamt;

   assign shamt = REQ.in1[4:0];

   always_comb begin
      OUT = '0;
      if (ALU_EN) begin
         unique case (REQ.func3)
            F3_ADD:  OUT = REQ.sub ? REQ.in0 - REQ.in1 : REQ.in0 + REQ.in1;
            F3_SLL:  OUT = REQ.in0 << shamt;
            F3_SLT:  OUT = {{(XLEN-1){1'b0}},
                            $signed(REQ.in0) < $signed(REQ.in1)};
            F3_SLTU: OUT = {{(XLEN-1){1'b0}}, REQ.in0 < REQ.in1};
            F3_XOR:  OUT = REQ.in0 ^ REQ.in1;
            F3_SR:   OUT = REQ.sub ? XLEN'($signed(REQ.in0) >>> shamt)
                                   : REQ.in0 >> shamt;
            F3_OR:   OUT = REQ.in0 | REQ.in1;
            F3_AND:  OUT = REQ.in0 & REQ.in1;
            default: OUT = '0;
         endcase
      end
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the port not granted last wins.
module rr_arb2 (
   input  logic [1:0] eligible,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (eligible)
         2'b11:   grant = last ? 2'b01 : 2'b10;
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU_DataPath between two requesters with round-robin issue
// and a per-port registered response slot with backpressure.
module alu_share_arbiter
   import alu_arb_pkg::*;
(
   input  logic                CLK,
   input  logic                RST_N,
   alu_share_arbiter_if.slave  bus,
   output logic                GRANT_LAST
);

   logic [1:0]           elig;
   logic [1:0]           grant;
   alu_req_t             alu_req;
   logic                 alu_en;
   logic [XLEN-1:0]      alu_out;

   logic [1:0]           rsp_valid_d, rsp_valid_q;
   logic [1:0][XLEN-1:0] rsp_data_d, rsp_data_q;
   logic                 grant_last_d, grant_last_q;

   // A full slot is still eligible if its consumer drains it this cycle
   assign elig = bus.REQ_VALID & (~rsp_valid_q | bus.RSP_READY);

   rr_arb2 u_arb (
      .eligible (elig),
      .last     (grant_last_q),
      .grant    (grant)
   );

   assign bus.REQ_READY = RST_N ? grant : 2'b00;
   assign alu_en        = |grant;

   always_comb begin
      alu_req = '{in0:   bus.REQ_IN0[0],
                  in1:   bus.REQ_IN1[0],
                  func3: bus.REQ_FUNC3[0],
                  sub:   bus.REQ_SUB[0]};
      if (grant[1]) begin
         alu_req = '{in0:   bus.REQ_IN0[1],
                     in1:   bus.REQ_IN1[1],
                     func3: bus.REQ_FUNC3[1],
                     sub:   bus.REQ_SUB[1]};
      end
   end

   ALU_DataPath u_alu (
      .ALU_EN (alu_en),
      .REQ    (alu_req),
      .OUT    (alu_out)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q & ~bus.RSP_READY;
      rsp_data_d   = rsp_data_q;
      grant_last_d = grant_last_q;
      for (int r = 0; r < 2; r++) begin
         if (grant[r]) begin
            rsp_valid_d[r] = 1'b1;
            rsp_data_d[r]  = alu_out;
         end
      end
      if (alu_en) begin
         grant_last_d = grant[1];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rsp_valid_q  <= 2'b00;
         rsp_data_q   <= '0;
         grant_last_q <= 1'b1;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         grant_last_q <= grant_last_d;
      end
   end

   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_DATA  = rsp_data_q;
   assign GRANT_LAST    = grant_last_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: arbitration/ALU reference model pushes expected results,
// a separate monitor pops and compares on every response handshake.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   logic CLK = 1'b0;
   logic RST_N;
   logic GRANT_LAST;

   alu_share_arbiter_if bus ();

   alu_share_arbiter dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .bus        (bus.slave),
      .GRANT_LAST (GRANT_LAST)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   alu_req_t    preq[2];
   logic        pend[2];
   logic        mvalid[2];
   logic [31:0] mdata[2];
   logic        mlast;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input alu_req_t r);
      int unsigned sh;
      logic signed [31:0] s;
      sh = r.in1 % 32;
      s  = r.in0;
      case (r.func3)
         3'd0: return r.sub ? r.in0 - r.in1 : r.in0 + r.in1;
         3'd1: return r.in0 << sh;
         3'd2: return ($signed(r.in0) < $signed(r.in1)) ? 32'd1 : 32'd0;
         3'd3: return (r.in0 < r.in1) ? 32'd1 : 32'd0;
         3'd4: return r.in0 ^ r.in1;
         3'd5: return r.sub ? 32'(s >>> sh) : r.in0 >> sh;
         3'd6: return r.in0 | r.in1;
         default: return r.in0 & r.in1;
      endcase
   endfunction

   task automatic load(input int p, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f,
                       input logic s);
      if (!pend[p]) begin
         preq[p] = '{in0: a, in1: b, func3: f, sub: s};
         pend[p] = 1'b1;
      end
   endtask

   task automatic cyc(input logic [1:0] rrdy, input logic rst = 1'b1);
      int win;
      logic [1:0] elig;
      logic [1:0] exp_rdy;
      logic [31:0] res;
      RST_N = rst;
      bus.RSP_READY = rrdy;
      for (int p = 0; p < 2; p++) begin
         bus.REQ_VALID[p] = pend[p];
         bus.REQ_IN0[p]   = preq[p].in0;
         bus.REQ_IN1[p]   = preq[p].in1;
         bus.REQ_FUNC3[p] = preq[p].func3;
         bus.REQ_SUB[p]   = preq[p].sub;
      end
      @(negedge CLK);
      for (int p = 0; p < 2; p++)
         elig[p] = pend[p] && (!mvalid[p] || rrdy[p]);
      if (elig == 2'b11)      win = (mlast == 1'b1) ? 0 : 1;
      else if (elig[0])       win = 0;
      else if (elig[1])       win = 1;
      else                    win = -1;
      exp_rdy = (rst && win >= 0) ? 2'(1 << win) : 2'b00;
      chk("req_ready", 32'(bus.REQ_READY), 32'(exp_rdy));
      chk("rsp_valid", 32'(bus.RSP_VALID), {30'd0, mvalid[1], mvalid[0]});
      chk("rsp_data0", bus.RSP_DATA[0], mdata[0]);
      chk("rsp_data1", bus.RSP_DATA[1], mdata[1]);
      chk("grant_last", 32'(GRANT_LAST), 32'(mlast));
      @(posedge CLK);
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            mvalid[p] = 1'b0;
            mdata[p]  = '0;
         end
         mlast = 1'b1;
         q0.delete();
         q1.delete();
      end else begin
         for (int p = 0; p < 2; p++)
            if (mvalid[p] && rrdy[p]) mvalid[p] = 1'b0;
         if (win >= 0) begin
            res = ref_alu(preq[win]);
            mvalid[win] = 1'b1;
            mdata[win]  = res;
            mlast       = win[0];
            pend[win]   = 1'b0;
            if (win == 0) q0.push_back(res);
            else          q1.push_back(res);
         end
      end
      #1;
   endtask

   always @(negedge CLK) begin
      if (bus.RSP_VALID[0] === 1'b1 && bus.RSP_READY[0] === 1'b1) begin
         if (q0.size() == 0) chk("sb0_empty", 32'd1, 32'd0);
         else chk("sb0_data", bus.RSP_DATA[0], q0.pop_front());
      end
      if (bus.RSP_VALID[1] === 1'b1 && bus.RSP_READY[1] === 1'b1) begin
         if (q1.size() == 0) chk("sb1_empty", 32'd1, 32'd0);
         else chk("sb1_data", bus.RSP_DATA[1], q1.pop_front());
      end
   end

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 3))
         0:       return $urandom_range(0, 40);
         1:       return 32'h8000_0000 | $urandom_range(0, 7);
         2:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0;
         preq[p] = '0;
      end
      bus.REQ_VALID = '0;
      bus.REQ_IN0   = '0;
      bus.REQ_IN1   = '0;
      bus.REQ_FUNC3 = '0;
      bus.REQ_SUB   = '0;
      bus.RSP_READY = '0;
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      for (int p = 0; p < 2; p++) begin
         mvalid[p] = 1'b0;
         mdata[p]  = '0;
      end
      mlast = 1'b1;
      #1;

      // single issue
      load(0, 32'd5, 32'd7, F3_ADD, 1'b0);
      cyc(2'b11);
      cyc(2'b11);
      chk("single_sum", bus.RSP_DATA[0], 32'd12);

      // contention
      for (int i = 0; i < 4; i++) begin
         load(0, 32'd3, 32'd5, F3_ADD, 1'b1);
         load(1, 32'h8000_0000, 32'd4, F3_SR, 1'b1);
         cyc(2'b11);
      end

      // backpressure on port 0
      cyc(2'b11);
      load(0, 32'd9, 32'd1, F3_XOR, 1'b0);
      cyc(2'b10);
      for (int i = 0; i < 4; i++) begin
         load(0, 32'd2, 32'd2, F3_OR, 1'b0);
         load(1, $urandom, $urandom, 3'($urandom), 1'($urandom));
         cyc(2'b10);
      end
      cyc(2'b11);
      cyc(2'b11);

      // drain plus reissue
      load(0, 32'd7, 32'd9, F3_ADD, 1'b0);
      cyc(2'b10);
      load(0, 32'd1, 32'hFFFF_FFFF, F3_SLTU, 1'b0);
      cyc(2'b11);
      chk("reissue_data", bus.RSP_DATA[0], 32'd1);
      cyc(2'b11);

      // reset mid-operation
      load(1, 32'hF0, 32'h0F, F3_OR, 1'b0);
      cyc(2'b00, 1'b0);
      chk("rst_valid", 32'(bus.RSP_VALID), 32'd0);
      load(0, 32'd1, 32'd2, F3_ADD, 1'b0);
      load(1, 32'd3, 32'd4, F3_ADD, 1'b0);
      cyc(2'b11);
      chk("rst_first_win", 32'(GRANT_LAST), 32'd0);
      cyc(2'b11);
      cyc(2'b11);

      // op sweep, alternating ports
      for (int f = 0; f < 8; f++) begin
         for (int s = 0; s < 2; s++) begin
            logic [31:0] b;
            b = ($urandom & 32'hFFFF_FFE0) |
                ((f == 1 || f == 5) && s == 1 ? 32'd31 : 32'($urandom % 32));
            load((f * 2 + s) % 2, rnd_op(), b, 3'(f), 1'(s));
            cyc(2'b11);
         end
      end

      // randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++)
            if ($urandom_range(0, 3) != 0)
               load(p, rnd_op(), rnd_op(), 3'($urandom), 1'($urandom));
         cyc(2'($urandom));
      end

      for (int i = 0; i < 6; i++) cyc(2'b11);
      chk("sb0_left", 32'(q0.size()), 32'd0);
      chk("sb1_left", 32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
